// File: rtl/exe_divider_pkg.sv
//==============================================================================
// Module   : exe_divider_pkg
// Brief    : Shared types and constants for the EXE-stage iterative divider.
// Revision : 1.0
//==============================================================================
`default_nettype none

package exe_divider_pkg;

    localparam int C_DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } DivStateType;

endpackage

`default_nettype wire

// File: rtl/exe_divider_div_step.sv
//==============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division iteration on {rem, quo}.
// Revision : 1.0
//==============================================================================
`default_nettype none

module div_step
    import exe_divider_pkg::*;
#(
    parameter int WIDTH = C_DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_rem_quo,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH-1:0] o_rem_quo
);

    logic [WIDTH:0]   w_partial;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    // Shifted remainder needs one extra bit; when it fits, the difference is below the divisor.
    assign w_partial = i_rem_quo[2*WIDTH-1:WIDTH-1];
    assign w_fits    = (w_partial >= {1'b0, i_divisor});
    assign w_diff    = w_partial[WIDTH-1:0] - i_divisor;

    assign o_rem_quo = {(w_fits ? w_diff : w_partial[WIDTH-1:0]),
                        i_rem_quo[WIDTH-2:0],
                        w_fits};

endmodule

`default_nettype wire

// File: rtl/exe_divider.sv
//==============================================================================
// Module   : exe_divider
// Brief    : Iterative restoring divider (DIV/DIVU) with pipeline stall and flush.
// Revision : 1.0
//==============================================================================
`default_nettype none

module exe_divider
    import exe_divider_pkg::*;
#(
    parameter int WIDTH = C_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int                 C_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    DivStateType          r_state;
    DivStateType          w_state_next;
    logic [C_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_rem_quo;
    logic [2*WIDTH-1:0]   w_rem_quo_next;
    logic [WIDTH-1:0]     r_divisor_mag;
    logic                 r_neg_quo;
    logic                 r_neg_rem;
    logic                 r_div_zero;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_dvd_mag;
    logic [WIDTH-1:0]     w_dvs_mag;
    logic [WIDTH-1:0]     w_quo_raw;
    logic [WIDTH-1:0]     w_rem_raw;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_accept  = (r_state == DIV_IDLE) & start & ~flush;
    assign w_last    = (r_state == DIV_CALC) & (r_count == C_LAST);
    assign w_dvd_mag = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .i_rem_quo (r_rem_quo),
        .i_divisor (r_divisor_mag),
        .o_rem_quo (w_rem_quo_next)
    );

    // Fix-up works on the final step's result so outputs are valid on entry to DIV_DONE.
    assign w_quo_raw = w_rem_quo_next[WIDTH-1:0];
    assign w_rem_raw = w_rem_quo_next[2*WIDTH-1:WIDTH];
    assign w_quo_fix = r_div_zero ? {WIDTH{1'b1}} : (r_neg_quo ? -w_quo_raw : w_quo_raw);
    assign w_rem_fix = r_neg_rem ? -w_rem_raw : w_rem_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DIV_IDLE: if (w_accept) w_state_next = DIV_CALC;
            DIV_CALC: if (r_count == C_LAST) w_state_next = DIV_DONE;
            DIV_DONE: w_state_next = DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
        if (flush) begin
            w_state_next = DIV_IDLE;
        end
        stall = w_accept | (r_state == DIV_CALC);
        done  = (r_state == DIV_DONE) & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count       <= '0;
            r_rem_quo     <= '0;
            r_divisor_mag <= '0;
            r_neg_quo     <= 1'b0;
            r_neg_rem     <= 1'b0;
            r_div_zero    <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
        end else if (w_accept) begin
            r_count       <= '0;
            r_rem_quo     <= {{WIDTH{1'b0}}, w_dvd_mag};
            r_divisor_mag <= w_dvs_mag;
            r_neg_quo     <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_rem     <= is_signed & dividend[WIDTH-1];
            r_div_zero    <= (divisor == '0);
        end else if ((r_state == DIV_CALC) && !flush) begin
            r_rem_quo <= w_rem_quo_next;
            r_count   <= r_count + 1'b1;
            if (w_last) begin
                r_quotient  <= w_quo_fix;
                r_remainder <= w_rem_fix;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

`default_nettype wire
